// File: rtl/div_pkg.sv
// div_pkg: shared op encodings, FSM states and datapath width for the divider issue controller.
package div_pkg;
    localparam int XLEN = 64;
    localparam int DIV_OP_UNSIGNED = 0;
    localparam int DIV_OP_REM = 1;
    localparam int DIV_OP_WORD = 2;
    localparam logic [2:0] DIV_OP_DIV = 3'b000;
    localparam logic [2:0] DIV_OP_DIVU = 3'b001;
    localparam logic [2:0] DIV_OP_REMS = 3'b010;
    localparam logic [2:0] DIV_OP_REMU = 3'b011;
    localparam logic [2:0] DIV_OP_DIVW = 3'b100;
    localparam logic [2:0] DIV_OP_DIVUW = 3'b101;
    localparam logic [2:0] DIV_OP_REMW = 3'b110;
    localparam logic [2:0] DIV_OP_REMUW = 3'b111;
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_WB    = 3'd3,
        S_DRAIN = 3'd4
    } state_t;
endpackage

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: one-deep issue/capture controller for the iterative divider, with flush drain.
// Optional DIV_ZERO_BYPASS_EN resolves divide-by-zero locally without using the divider.
module div_issue_ctrl #(
    parameter int TAG_W = 6,
    parameter int XLEN  = div_pkg::XLEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             uop_valid,
    output logic             uop_ready,
    input  logic [XLEN-1:0]  uop_op1,
    input  logic [XLEN-1:0]  uop_op2,
    input  logic [2:0]       uop_div_op,
    input  logic [TAG_W-1:0] uop_tag,
    input  logic             flush,
    output logic             div_req_valid,
    input  logic             div_req_ready,
    output logic [XLEN-1:0]  div_operand1,
    output logic [XLEN-1:0]  div_operand2,
    output logic [2:0]       div_op,
    input  logic             div_resp_valid,
    input  logic [XLEN-1:0]  div_resp_result,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [XLEN-1:0]  wb_data,
    output logic [TAG_W-1:0] wb_tag
);
    import div_pkg::*;

    state_t           state_q, state_d;
    logic [XLEN-1:0]  op1_q, op1_d, op2_q, op2_d, data_q, data_d;
    logic [2:0]       op_q, op_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             accept, bypass;
    logic [XLEN-1:0]  bypass_data;

    assign uop_ready     = (state_q == S_IDLE) && !flush;
    assign div_req_valid = (state_q == S_ISSUE);
    assign wb_valid      = (state_q == S_WB);
    assign div_operand1  = op1_q;
    assign div_operand2  = op2_q;
    assign div_op        = op_q;
    assign wb_data       = data_q;
    assign wb_tag        = tag_q;
    assign accept        = uop_valid && uop_ready;

`ifdef DIV_ZERO_BYPASS_EN
    function automatic logic [XLEN-1:0] zero_div_result(input logic [2:0] op, input logic [XLEN-1:0] a);
        return !op[DIV_OP_REM] ? '1 : op[DIV_OP_WORD] ? {{(XLEN-32){a[31]}}, a[31:0]} : a;
    endfunction
    assign bypass      = uop_div_op[DIV_OP_WORD] ? (uop_op2[31:0] == '0) : (uop_op2 == '0);
    assign bypass_data = zero_div_result(uop_div_op, uop_op1);
`else
    assign bypass      = 1'b0;
    assign bypass_data = '0;
`endif

    always_comb begin
        state_d = state_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        op_d    = op_q;
        tag_d   = tag_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op1_d   = uop_op1;
                    op2_d   = uop_op2;
                    op_d    = uop_div_op;
                    tag_d   = uop_tag;
                    data_d  = bypass ? bypass_data : data_q;
                    state_d = bypass ? S_WB : S_ISSUE;
                end
            end
            // a flushed request that still handshakes must be drained: the divider cannot abort
            S_ISSUE: state_d = div_req_ready ? (flush ? S_DRAIN : S_WAIT) : (flush ? S_IDLE : S_ISSUE);
            S_WAIT: begin
                state_d = div_resp_valid ? (flush ? S_IDLE : S_WB) : (flush ? S_DRAIN : S_WAIT);
                data_d  = (div_resp_valid && !flush) ? div_resp_result : data_q;
            end
            S_WB:    state_d = (wb_ready || flush) ? S_IDLE : S_WB;
            S_DRAIN: state_d = div_resp_valid ? S_IDLE : S_DRAIN;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op1_q   <= '0;
            op2_q   <= '0;
            op_q    <= '0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            op_q    <= op_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end
endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb_div_issue_ctrl: directed vector table plus flush/reset sequences against a behavioural divider.
module tb_div_issue_ctrl;
    localparam int TAG_W = 6;

    logic             clk, rst_n;
    logic             uop_valid, uop_ready, flush;
    logic [63:0]      uop_op1, uop_op2;
    logic [2:0]       uop_div_op;
    logic [TAG_W-1:0] uop_tag;
    logic             div_req_valid, div_req_ready;
    logic [63:0]      div_operand1, div_operand2;
    logic [2:0]       div_op;
    logic             div_resp_valid;
    logic [63:0]      div_resp_result;
    logic             wb_valid, wb_ready;
    logic [63:0]      wb_data;
    logic [TAG_W-1:0] wb_tag;

    div_issue_ctrl #(.TAG_W(TAG_W), .XLEN(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .uop_valid(uop_valid), .uop_ready(uop_ready), .uop_op1(uop_op1), .uop_op2(uop_op2),
        .uop_div_op(uop_div_op), .uop_tag(uop_tag), .flush(flush),
        .div_req_valid(div_req_valid), .div_req_ready(div_req_ready),
        .div_operand1(div_operand1), .div_operand2(div_operand2), .div_op(div_op),
        .div_resp_valid(div_resp_valid), .div_resp_result(div_resp_result),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_tag(wb_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // behavioural RISC-V divider that the bench uses as the downstream unit
    function automatic logic [63:0] rv_div(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] x, y, q, r, res;
        x = a;
        y = b;
        if (op[2]) begin
            x = op[0] ? {32'b0, a[31:0]} : {{32{a[31]}}, a[31:0]};
            y = op[0] ? {32'b0, b[31:0]} : {{32{b[31]}}, b[31:0]};
        end
        if (y == 64'd0) begin q = '1; r = x; end
        else if (op[0]) begin q = x / y; r = x % y; end
        else if (x == 64'h8000_0000_0000_0000 && y == '1) begin q = x; r = 64'd0; end
        else begin q = $signed(x) / $signed(y); r = $signed(x) % $signed(y); end
        res = op[1] ? r : q;
        if (op[2]) res = {{32{res[31]}}, res[31:0]};
        return res;
    endfunction

    logic        busy, hold_ready, hs;
    int          cnt, div_lat = 8, req_cnt, resp_cnt, wb_cnt = 0;
    logic [63:0] cap1, cap2;
    logic [2:0]  capop;
    assign div_req_ready = !busy && !hold_ready;

    initial begin
        busy = 1'b0; div_resp_valid = 1'b0; div_resp_result = '0;
        req_cnt = 0; resp_cnt = 0; cnt = 0; cap1 = '0; cap2 = '0; capop = '0;
        forever begin
            @(negedge clk);
            hs = div_req_valid && div_req_ready;
            if (hs) begin cap1 = div_operand1; cap2 = div_operand2; capop = div_op; req_cnt++; end
            @(posedge clk); #1;
            div_resp_valid = 1'b0;
            if (hs) begin busy = 1'b1; cnt = div_lat; end
            else if (busy) begin
                cnt--;
                if (cnt == 0) begin
                    busy = 1'b0; div_resp_valid = 1'b1;
                    div_resp_result = rv_div(capop, cap1, cap2);
                    resp_cnt++;
                end
            end
        end
    end

    always @(negedge clk) if (wb_valid && wb_ready) wb_cnt <= wb_cnt + 1;

    typedef struct {
        logic [2:0]  op;
        logic [63:0] a, b;
        logic [5:0]  tag;
        int          hold;
        logic [63:0] exp;
    } vec_t;
    vec_t vecs[13];

    task automatic accept_uop(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b, input logic [5:0] tag);
        int g = 0;
        @(posedge clk); #1;
        uop_valid = 1'b1; uop_div_op = op; uop_op1 = a; uop_op2 = b; uop_tag = tag;
        @(negedge clk);
        while (!uop_ready && g < 200) begin g++; @(negedge clk); end
        chk("accept_ready", uop_ready, 1);
        @(posedge clk); #1;
        uop_valid = 1'b0;
    endtask

    task automatic wait_wb(output int lat);
        lat = 0;
        @(negedge clk);
        while (!wb_valid && lat < 300) begin lat++; @(negedge clk); end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat, r0, w0;
        logic byp;
`ifdef DIV_ZERO_BYPASS_EN
        byp = v.op[2] ? (v.b[31:0] == 32'd0) : (v.b == 64'd0);
`else
        byp = 1'b0;
`endif
        r0 = req_cnt; w0 = wb_cnt;
        wb_ready = (v.hold == 0);
        accept_uop(v.op, v.a, v.b, v.tag);
        wait_wb(lat);
        chk($sformatf("v%0d_latency", idx), lat, byp ? 0 : div_lat + 2);
        for (int i = 0; i < v.hold; i++) begin
            chk($sformatf("v%0d_hold%0d", idx, i), {wb_valid, wb_tag, wb_data}, {1'b1, v.tag, v.exp});
            @(posedge clk); #1;
            if (i == v.hold - 1) wb_ready = 1'b1;
            @(negedge clk);
        end
        chk($sformatf("v%0d_wb", idx), {wb_valid, wb_tag, wb_data}, {1'b1, v.tag, v.exp});
        @(negedge clk);
        chk($sformatf("v%0d_after_wb", idx), {wb_valid, uop_ready}, 2'b01);
        chk($sformatf("v%0d_req_count", idx), req_cnt - r0, byp ? 0 : 1);
        if (!byp) chk($sformatf("v%0d_req_operands", idx), {capop, cap1, cap2}, {v.op, v.a, v.b});
        @(negedge clk);
        chk($sformatf("v%0d_wb_count", idx), wb_cnt - w0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, r0, w0, q0, low;
        vecs[0]  = '{3'b000, 64'd100, 64'd7, 6'd5, 0, 64'd14};
        vecs[1]  = '{3'b010, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 6'd6, 0, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[2]  = '{3'b100, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 6'd7, 0, 64'hFFFF_FFFF_8000_0000};
        vecs[3]  = '{3'b001, 64'd1000, 64'd10, 6'd9, 20, 64'd100};
        vecs[4]  = '{3'b011, 64'd17, 64'd5, 6'd10, 0, 64'd2};
        vecs[5]  = '{3'b000, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 6'd11, 0, 64'hFFFF_FFFF_FFFF_FFFA};
        vecs[6]  = '{3'b110, 64'h1_0000_000B, 64'd4, 6'd12, 0, 64'd3};
        vecs[7]  = '{3'b101, 64'hFFFF_FFFF, 64'd2, 6'd13, 0, 64'h7FFF_FFFF};
        vecs[8]  = '{3'b000, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 6'd14, 0, 64'h8000_0000_0000_0000};
        vecs[9]  = '{3'b001, 64'd5, 64'd0, 6'd15, 0, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[10] = '{3'b110, 64'h1_8000_0000, 64'd0, 6'd16, 0, 64'hFFFF_FFFF_8000_0000};
        vecs[11] = '{3'b100, 64'd7, 64'h1_0000_0000, 6'd17, 0, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[12] = '{3'b010, 64'd123, 64'd0, 6'd18, 0, 64'd123};

        rst_n = 1'b0; uop_valid = 1'b0; flush = 1'b0; wb_ready = 1'b0; hold_ready = 1'b0;
        uop_op1 = '0; uop_op2 = '0; uop_div_op = '0; uop_tag = '0;
        @(negedge clk);
        chk("reset_ctrl", {div_req_valid, wb_valid, uop_ready, div_op, wb_tag}, {3'b001, 3'd0, 6'd0});
        chk("reset_data", {div_operand1, div_operand2}, 128'd0);
        chk("reset_wb_data", wb_data, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

        // flush while waiting: the discarded response must arrive before the next accept
        div_lat = 20; wb_ready = 1'b1; w0 = wb_cnt; q0 = resp_cnt;
        accept_uop(3'b000, 64'd100, 64'd7, 6'd1);
        repeat (11) @(posedge clk);
        #1;
        flush = 1'b1; uop_valid = 1'b1; uop_div_op = 3'b000; uop_op1 = 64'd9; uop_op2 = 64'd3; uop_tag = 6'd2;
        @(posedge clk); #1;
        flush = 1'b0;
        low = 0;
        @(negedge clk);
        while (!uop_ready && low < 200) begin low++; @(negedge clk); end
        chk("drain_ready_low_cycles", low, 10);
        chk("drain_resp_before_ready", resp_cnt - q0, 1);
        @(posedge clk); #1;
        uop_valid = 1'b0;
        wait_wb(lat);
        chk("drain_new_wb", {wb_valid, wb_tag, wb_data}, {1'b1, 6'd2, 64'd3});
        @(negedge clk);
        @(negedge clk);
        chk("drain_wb_count", wb_cnt - w0, 1);

        // flush in ISSUE while the divider is not ready
        div_lat = 8; hold_ready = 1'b1; r0 = req_cnt; w0 = wb_cnt;
        @(posedge clk); #1;
        uop_valid = 1'b1; uop_div_op = 3'b001; uop_op1 = 64'd50; uop_op2 = 64'd5; uop_tag = 6'd3;
        @(negedge clk);
        chk("issue_flush_accept_ready", uop_ready, 1);
        @(posedge clk); #1;
        uop_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        chk("issue_flush_req_high", div_req_valid, 1);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("issue_flush_idle", {div_req_valid, wb_valid, uop_ready}, 3'b001);
        hold_ready = 1'b0;
        repeat (5) @(negedge clk);
        chk("issue_flush_no_req", req_cnt - r0, 0);
        chk("issue_flush_no_wb", wb_cnt - w0, 0);

        // asynchronous reset in WAIT: outputs clear between clock edges
        div_lat = 20;
        accept_uop(3'b001, 64'd1000, 64'd10, 6'd7);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_ctrl", {div_req_valid, wb_valid, div_op, wb_tag}, 11'd0);
        chk("async_rst_operands", {div_operand1, div_operand2}, 128'd0);
        chk("async_rst_wb_data", wb_data, 0);
        low = 0;
        while (busy && low < 100) begin low++; @(negedge clk); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", {wb_valid, div_req_valid, uop_ready}, 3'b001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
- Initiator-side controller for the 64-bit iterative divider functional unit.
- Accepts one divide micro-op from the issue stage and drives the divider's req_valid/req_ready handshake.
- Captures the divider's single-cycle resp_valid pulse and holds the result with its ROB tag until writeback accepts it. This provides the backpressure the divider itself lacks.
- Tracks a pipeline flush so a killed in-flight divide drains silently.

Parameters:
- TAG_W, 6, width of the ROB tag carried with each micro-op.
- XLEN, 64, operand/result width; only 64 is supported.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- uop_valid  in  1  issue stage presents a divide micro-op
- uop_ready  out  1  controller accepts the micro-op
- uop_op1  in  XLEN  dividend
- uop_op2  in  XLEN  divisor
- uop_div_op  in  3  [0]=unsigned, [1]=remainder, [2]=word (DIV=000 DIVU=001 REM=010 REMU=011 DIVW=100 ... REMUW=111)
- uop_tag  in  TAG_W  ROB tag
- flush  in  1  kill any held or in-flight micro-op
- div_req_valid  out  1  request to divider
- div_req_ready  in  1  divider idle
- div_operand1  out  XLEN  registered dividend
- div_operand2  out  XLEN  registered divisor
- div_op  out  3  registered op code
- div_resp_valid  in  1  divider result pulse, one cycle, no backpressure
- div_resp_result  in  XLEN  divider result
- wb_valid  out  1  result ready for writeback
- wb_ready  in  1  writeback accepts
- wb_data  out  XLEN  result
- wb_tag  out  TAG_W  tag of result

Behaviour:
- Reset (async, rst_n=0): state=IDLE; div_req_valid=0, wb_valid=0; operand, op, data and tag registers=0.
- States: IDLE, ISSUE, WAIT, WB, DRAIN (3-bit encoding).
- Output decode:
  - uop_ready = (state==IDLE) && !flush.
  - div_req_valid = (state==ISSUE).
  - wb_valid = (state==WB).
- IDLE:
  - On uop_valid && uop_ready: latch op1, op2, div_op and tag; go to ISSUE.
- ISSUE:
  - div_req_valid && div_req_ready -> WAIT.
  - Operands stay stable while div_req_valid is high.
- WAIT:
  - On div_resp_valid: latch div_resp_result into wb_data; go to WB.
  - div_resp_valid outside WAIT/DRAIN is ignored (protocol error, no state change).
- WB:
  - wb_ready -> IDLE.
  - wb_data and wb_tag stay stable while wb_valid && !wb_ready.
- DRAIN:
  - Wait for div_resp_valid, discard the result, go to IDLE.
  - The divider cannot be aborted, so no new request is issued before its response.
- Flush (priority over all other transitions):
  - IDLE: uop not accepted.
  - ISSUE with div_req_ready=1 in the same cycle: the handshake still completes -> DRAIN.
  - ISSUE with div_req_ready=0 -> IDLE.
  - WAIT -> DRAIN.
  - WAIT with div_resp_valid in the same cycle: result dropped -> IDLE.
  - WB -> IDLE; wb_valid drops next cycle; a same-cycle wb_ready still counts as accepted.
  - DRAIN: stays in DRAIN.
- Latency, uop accept to wb_valid: 1 (ISSUE) + divider latency (≤66 cycles for 64-bit, ≤34 for word) + 1 capture.
- At most one micro-op in flight; no back-to-back accept in the same cycle WB exits.

Optional Feature:
- Macro: DIV_ZERO_BYPASS_EN.
- Defined: divisor-zero micro-ops are resolved locally. Zero test is op2[31:0]==0 for word ops, op2==0 otherwise.
  - Go IDLE -> WB directly; the divider is never requested.
  - Quotient result = all ones (0xFFFF_FFFF_FFFF_FFFF).
  - Remainder result = op1 for 64-bit ops, sign-extended op1[31:0] for word ops.
  - wb_valid is asserted the cycle after acceptance.
- Undefined: all ops go through the divider; results are identical, latency is the full divider latency.

Decomposition:
- Shared package div_pkg holds:
  - div_op encodings and bit indices (DIV_OP_UNSIGNED=0, DIV_OP_REM=1, DIV_OP_WORD=2).
  - State localparams.
  - XLEN.
- No sub-module; the optional bypass result generation is a local function.

Test Plan:
- DIV 100/7 (op=000, tag=5) with wb_ready=1 -> exactly one div request with operands 100/7; wb_valid with wb_data=14, wb_tag=5; uop_ready high again the cycle after WB handshake.
- REM -7/2 (op=010) -> wb_data=0xFFFF_FFFF_FFFF_FFFF (-1); DIVW 0x0000_0000_8000_0000 / -1 (op=100) -> wb_data=0xFFFF_FFFF_8000_0000.
- DIVU 1000/10 with wb_ready held low 20 cycles -> wb_valid stays high, wb_data=100 stable throughout; accepted on the first cycle wb_ready=1.
- Flush 10 cycles into WAIT, then new uop DIV 9/3 presented -> uop_ready stays low until the discarded response arrives; the only wb_valid carries 3 with the new tag.
- Flush in ISSUE with div_req_ready=0 -> div_req_valid drops next cycle, state IDLE, no wb_valid; reset asserted in WAIT -> all outputs 0 immediately, without waiting for clk.
- With DIV_ZERO_BYPASS_EN: DIVU 5/0 -> wb_valid one cycle after accept, data 0xFFFF_FFFF_FFFF_FFFF, div_req_valid never asserted; REMW 0x1_8000_0000/0 -> wb_data=0xFFFF_FFFF_8000_0000.
